// File: rtl/mips32_pkg.sv
// Shared constants for the mips32 interrupt path: line count and interrupt-id encoding.
package mips32_pkg;

   localparam int unsigned NUM_IRQ  = 5;
   localparam int unsigned IRQ_ID_W = 3;

   typedef logic [IRQ_ID_W-1:0] irq_id_t;

   localparam irq_id_t NO_IRQ_ID = '0;

endpackage

// File: rtl/irq_sync.sv
// Single-line synchronizer chain followed by a previous-value flop for rising-edge detection.
module irq_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic sync,
   output logic rise_c
);

   logic [SYNC_STAGES-1:0] stage_q;
   logic                   prev_q;

   // Reset empties the chain so any edge in flight is dropped.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stage_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         stage_q <= {stage_q[SYNC_STAGES-2:0], d};
         prev_q  <= stage_q[SYNC_STAGES-1];
      end
   end

   assign sync   = stage_q[SYNC_STAGES-1];
   assign rise_c = sync & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding mips32 interrupts: sync, mask, pending/overrun, priority encode.
// Define IRQ_CTRL_EDGE_EN for edge-latched pending with ack/overrun; default build is level mode.
module irq_ctrl
   import mips32_pkg::IRQ_ID_W;
   import mips32_pkg::NO_IRQ_ID;
#(
   parameter int unsigned NUM_IRQ     = mips32_pkg::NUM_IRQ,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_IRQ-1:0]  irq_src,
   input  logic                mask_we,
   input  logic [NUM_IRQ-1:0]  mask_wdata,
   input  logic                ack,
   input  logic [IRQ_ID_W-1:0] ack_id,
   output logic [NUM_IRQ-1:0]  interrupts,
   output logic                irq_valid,
   output logic [IRQ_ID_W-1:0] irq_id,
   output logic [NUM_IRQ-1:0]  pending,
   output logic [NUM_IRQ-1:0]  overrun
);

   logic [NUM_IRQ-1:0] sync_lvl;
   logic [NUM_IRQ-1:0] rise_c;
   logic [NUM_IRQ-1:0] mask_q;
   logic [NUM_IRQ-1:0] pending_r;
   logic [NUM_IRQ-1:0] overrun_r;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
      irq_sync #(
         .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
         .clk    (clk),
         .rst    (rst),
         .d      (irq_src[g]),
         .sync   (sync_lvl[g]),
         .rise_c (rise_c[g])
      );
   end

   // Mask resets to all-enabled; writes are blocked while in reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         mask_q <= '1;
      end else if (mask_we) begin
         mask_q <= mask_wdata;
      end
   end

`ifdef IRQ_CTRL_EDGE_EN

   logic [NUM_IRQ-1:0] ack_hit_c;
   logic [NUM_IRQ-1:0] pending_d;
   logic [NUM_IRQ-1:0] overrun_d;
   logic               unused_lvl_c;

   // Out-of-range ack_id never matches a line, so it leaves all state alone.
   always_comb begin
      ack_hit_c = '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         ack_hit_c[i] = ack && (ack_id == IRQ_ID_W'(i));
      end
   end

   // A new edge always wins over an ack on the same line so the edge is not lost.
   always_comb begin
      pending_d = pending_r;
      overrun_d = overrun_r;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
         if (rise_c[i]) begin
            pending_d[i] = 1'b1;
            overrun_d[i] = ack_hit_c[i] ? 1'b0 : (overrun_r[i] | pending_r[i]);
         end else if (ack_hit_c[i]) begin
            pending_d[i] = 1'b0;
            overrun_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pending_r <= '0;
         overrun_r <= '0;
      end else begin
         pending_r <= pending_d;
         overrun_r <= overrun_d;
      end
   end

   assign unused_lvl_c = ^sync_lvl;

`else

   logic unused_edge_c;

   // Level mode: pending simply tracks the synchronized request lines.
   assign pending_r     = sync_lvl;
   assign overrun_r     = '0;
   assign unused_edge_c = ^{rise_c, ack, ack_id};

`endif

   assign pending    = pending_r;
   assign overrun    = overrun_r;
   assign interrupts = pending_r & mask_q;
   assign irq_valid  = |interrupts;

   // Lowest index wins: scan downward so the last hit is the lowest set bit.
   always_comb begin
      irq_id = NO_IRQ_ID;
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (interrupts[i]) begin
            irq_id = IRQ_ID_W'(i);
         end
      end
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic against a history-based model.
module tb_irq_ctrl;

   localparam int unsigned N = 5;
   localparam int unsigned S = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] irq_src;
   logic         mask_we;
   logic [N-1:0] mask_wdata;
   logic         ack;
   logic [2:0]   ack_id;
   logic [N-1:0] interrupts;
   logic         irq_valid;
   logic [2:0]   irq_id;
   logic [N-1:0] pending;
   logic [N-1:0] overrun;

   irq_ctrl #(
      .NUM_IRQ     (N),
      .SYNC_STAGES (S)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_src    (irq_src),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ack        (ack),
      .ack_id     (ack_id),
      .interrupts (interrupts),
      .irq_valid  (irq_valid),
      .irq_id     (irq_id),
      .pending    (pending),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_mism = 0;

   // Model state: hist[k] is the irq_src value sampled k+1 edges ago.
   logic [N-1:0] hist [0:S];
   logic [N-1:0] m_pend;
   logic [N-1:0] m_ovr;
   logic [N-1:0] m_mask;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mism++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] lowest(input logic [N-1:0] v);
      for (int i = 0; i < int'(N); i++) begin
         if (v[i]) return 3'(i);
      end
      return 3'd0;
   endfunction

   task automatic model_step();
`ifdef IRQ_CTRL_EDGE_EN
      logic [N-1:0] rise;
`endif
      if (!rst) begin
         for (int k = 0; k <= int'(S); k++) hist[k] = '0;
         m_pend = '0;
         m_ovr  = '0;
         m_mask = '1;
         return;
      end
`ifdef IRQ_CTRL_EDGE_EN
      rise = hist[S-1] & ~hist[S];
      for (int i = 0; i < int'(N); i++) begin
         if (rise[i]) begin
            if (ack && ack_id == 3'(i)) begin
               m_ovr[i] = 1'b0;
            end else if (m_pend[i]) begin
               m_ovr[i] = 1'b1;
            end
            m_pend[i] = 1'b1;
         end else if (ack && ack_id == 3'(i)) begin
            m_pend[i] = 1'b0;
            m_ovr[i]  = 1'b0;
         end
      end
`endif
      if (mask_we) m_mask = mask_wdata;
      for (int k = int'(S); k > 0; k--) hist[k] = hist[k-1];
      hist[0] = irq_src;
`ifndef IRQ_CTRL_EDGE_EN
      m_pend = hist[S-1];
`endif
   endtask

   task automatic check_all(input string tag);
      logic [N-1:0] exp_int;
      exp_int = m_pend & m_mask;
      check({tag, ".interrupts"}, 8'(interrupts), 8'(exp_int));
      check({tag, ".irq_valid"},  8'(irq_valid),  8'(|exp_int));
      check({tag, ".irq_id"},     8'(irq_id),     8'(lowest(exp_int)));
      check({tag, ".pending"},    8'(pending),    8'(m_pend));
      check({tag, ".overrun"},    8'(overrun),    8'(m_ovr));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all("model");
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   initial begin
      for (int k = 0; k <= int'(S); k++) hist[k] = '0;
      m_pend = '0;
      m_ovr  = '0;
      m_mask = '1;
      rst = 1'b0; irq_src = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; ack_id = 3'd0;
      ticks(2);
      check("rst.interrupts", 8'(interrupts), 8'h00);
      check("rst.irq_valid",  8'(irq_valid),  8'h00);
      check("rst.irq_id",     8'(irq_id),     8'h00);
      check("rst.pending",    8'(pending),    8'h00);
      check("rst.overrun",    8'(overrun),    8'h00);
      rst = 1'b1;
      ticks(2);

`ifdef IRQ_CTRL_EDGE_EN
      // Edge capture latency
      irq_src = 5'b00100;
      tick(); check("cap.e1", 8'(pending), 8'h00);
      tick(); check("cap.e2", 8'(pending), 8'h00);
      tick();
      check("cap.pending",    8'(pending),    8'h04);
      check("cap.interrupts", 8'(interrupts), 8'h04);
      check("cap.irq_id",     8'(irq_id),     8'd2);
      check("cap.irq_valid",  8'(irq_valid),  8'd1);
      ack = 1'b1; ack_id = 3'd2; irq_src = '0;
      tick(); ack = 1'b0;
      ticks(2);

      // Priority and ack
      irq_src = 5'b01010;
      ticks(3);
      check("prio.irq_id1", 8'(irq_id), 8'd1);
      ack = 1'b1; ack_id = 3'd1;
      tick(); ack = 1'b0;
      check("prio.irq_id3", 8'(irq_id), 8'd3);
      ack = 1'b1; ack_id = 3'd3;
      tick(); ack = 1'b0;
      check("prio.valid0", 8'(irq_valid), 8'd0);
      irq_src = '0;
      ticks(3);

      // Masked line still latches pending
      mask_we = 1'b1; mask_wdata = 5'b11110;
      tick(); mask_we = 1'b0;
      irq_src = 5'b00001;
      ticks(3);
      check("mask.pending",    8'(pending),    8'h01);
      check("mask.interrupts", 8'(interrupts), 8'h00);
      mask_we = 1'b1; mask_wdata = 5'b11111;
      tick(); mask_we = 1'b0;
      check("unmask.interrupts", 8'(interrupts), 8'h01);
      ack = 1'b1; ack_id = 3'd0; irq_src = '0;
      tick(); ack = 1'b0;
      ticks(2);

      // Overrun, out-of-range ack, edge/ack collision
      irq_src = 5'b10000;
      ticks(3);
      check("ovr.first", 8'(overrun), 8'h00);
      irq_src = '0;
      ticks(3);
      irq_src = 5'b10000;
      ticks(3);
      check("ovr.set",     8'(overrun), 8'h10);
      check("ovr.pending", 8'(pending), 8'h10);
      ack = 1'b1; ack_id = 3'd6;
      tick(); ack = 1'b0;
      check("ack6.pending", 8'(pending), 8'h10);
      check("ack6.overrun", 8'(overrun), 8'h10);
      irq_src = '0;
      ticks(3);
      irq_src = 5'b10000;
      ticks(2);
      ack = 1'b1; ack_id = 3'd4;
      tick(); ack = 1'b0;
      check("coll.pending", 8'(pending), 8'h10);
      check("coll.overrun", 8'(overrun), 8'h00);

      // Reset mid-operation
      ack = 1'b1; ack_id = 3'd4; irq_src = '0;
      tick(); ack = 1'b0;
      ticks(2);
      irq_src = 5'b10101;
      ticks(3);
      check("mid.pending", 8'(pending), 8'h15);
      mask_we = 1'b1; mask_wdata = 5'b00100;
      tick();
      irq_src = 5'b00001; rst = 1'b0; mask_wdata = 5'b00000; ack = 1'b1; ack_id = 3'd0;
      tick();
      check("mid.rst.interrupts", 8'(interrupts), 8'h00);
      check("mid.rst.pending",    8'(pending),    8'h00);
      check("mid.rst.irq_valid",  8'(irq_valid),  8'h00);
      rst = 1'b1; mask_we = 1'b0; ack = 1'b0;
      ticks(2);
      check("mid.rel.e2", 8'(pending), 8'h00);
      tick();
      check("mid.rel.pending",    8'(pending),    8'h01);
      check("mid.rel.interrupts", 8'(interrupts), 8'h01);
      ticks(3);
      check("mid.held.pending", 8'(pending), 8'h01);
      check("mid.held.overrun", 8'(overrun), 8'h00);
      irq_src = '0;
      ticks(3);
`else
      // Level mode follows the synchronized line
      irq_src = 5'b01000;
      tick(); check("lvl.e1", 8'(interrupts), 8'h00);
      tick();
      check("lvl.interrupts", 8'(interrupts), 8'h08);
      check("lvl.irq_id",     8'(irq_id),     8'd3);
      check("lvl.irq_valid",  8'(irq_valid),  8'd1);
      check("lvl.overrun",    8'(overrun),    8'h00);
      irq_src = '0; ack = 1'b1; ack_id = 3'd3;
      tick(); ack = 1'b0;
      check("lvl.ack.ignored", 8'(interrupts), 8'h08);
      tick();
      check("lvl.fall", 8'(interrupts), 8'h00);

      mask_we = 1'b1; mask_wdata = 5'b11110;
      tick(); mask_we = 1'b0;
      irq_src = 5'b00001;
      ticks(2);
      check("lvl.mask.pending",    8'(pending),    8'h01);
      check("lvl.mask.interrupts", 8'(interrupts), 8'h00);
      mask_we = 1'b1; mask_wdata = 5'b11111;
      tick(); mask_we = 1'b0;
      check("lvl.unmask", 8'(interrupts), 8'h01);

      mask_we = 1'b1; mask_wdata = 5'b00100;
      tick();
      rst = 1'b0; mask_wdata = 5'b00000;
      tick();
      check("lvl.rst.pending",    8'(pending),    8'h00);
      check("lvl.rst.interrupts", 8'(interrupts), 8'h00);
      rst = 1'b1; mask_we = 1'b0;
      tick();
      check("lvl.rel.e1", 8'(pending), 8'h00);
      tick();
      check("lvl.rel.interrupts", 8'(interrupts), 8'h01);
      irq_src = '0;
      ticks(2);
`endif

      // Random traffic against the model
      for (int c = 0; c < 800; c++) begin
         rst     = ($urandom_range(0, 63) != 0);
         if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
         mask_we = ($urandom_range(0, 7) == 0);
         mask_wdata = ($urandom_range(0, 1) == 0) ? N'($urandom) : '1;
         ack     = ($urandom_range(0, 2) == 0);
         ack_id  = ($urandom_range(0, 1) == 0) ? lowest(m_pend) : 3'($urandom_range(0, 7));
         tick();
      end
      rst = 1'b1; ack = 1'b0; mask_we = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mism);
      $finish;
   end

endmodule
